// File: rtl/dca_matrix_lsu_wdata_sender_pkg.sv
// rtl/dca_matrix_lsu_wdata_sender_pkg.sv - shared types and txn-info field layout for the LSU write-data sender
// txn_info layout (msb..lsb): {skip, rsvd, alen[7:0], bitaddr[BW_BITADDR-1:0]}
package dca_matrix_lsu_wdata_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int TXN_ALEN_W = 8;

    function automatic int txn_info_width(input int bw_bitaddr);
        return bw_bitaddr + TXN_ALEN_W + 2;
    endfunction

    function automatic int txn_alen_lsb(input int bw_bitaddr);
        return bw_bitaddr;
    endfunction

    function automatic int txn_skip_pos(input int bw_bitaddr);
        return bw_bitaddr + TXN_ALEN_W + 1;
    endfunction

    function automatic int row_buffer_width(input int bw_axi_data, input int max_num_axi_data);
        return bw_axi_data * max_num_axi_data;
    endfunction

endpackage

// File: rtl/dca_matrix_lsu_wdata_sender.sv
// rtl/dca_matrix_lsu_wdata_sender.sv - slices a latched row buffer into AXI W beats and waits for B
// Optional macro DCA_LSU_WSENDER_BRESP_CHECK_EN: report bresp[1] of the B handshake as done_error_o.
module dca_matrix_lsu_wdata_sender
    import dca_matrix_lsu_wdata_sender_pkg::*;
#(
    parameter  int BW_AXI_DATA          = 32,
    parameter  int MAX_NUM_AXI_DATA     = 4,
    parameter  int BW_BITADDR           = 32,
    localparam int BW_TXN_INFO          = txn_info_width(BW_BITADDR),
    localparam int BW_MEMORY_ROW_BUFFER = row_buffer_width(BW_AXI_DATA, MAX_NUM_AXI_DATA),
    localparam int BW_STRB              = BW_AXI_DATA / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic                            txn_valid_i,
    output logic                            txn_ready_o,
    input  logic [BW_TXN_INFO-1:0]          txn_info_i,
    input  logic [BW_MEMORY_ROW_BUFFER-1:0] row_data_i,
    output logic                            wvalid_o,
    input  logic                            wready_i,
    output logic [BW_AXI_DATA-1:0]          wdata_o,
    output logic [BW_STRB-1:0]              wstrb_o,
    output logic                            wlast_o,
    input  logic                            bvalid_i,
    output logic                            bready_o,
    input  logic [1:0]                      bresp_i,
    output logic                            done_valid_o,
    input  logic                            done_ready_i,
    output logic [BW_TXN_INFO-1:0]          done_info_o,
    output logic                            done_error_o
);

    localparam int ALEN_LSB = txn_alen_lsb(BW_BITADDR);
    localparam int SKIP_POS = txn_skip_pos(BW_BITADDR);

    state_t                          state_q;
    logic [TXN_ALEN_W-1:0]           cnt_q;
    logic [BW_MEMORY_ROW_BUFFER-1:0] row_q;
    logic [BW_TXN_INFO-1:0]          info_q;
    logic                            err_q;

    logic [TXN_ALEN_W-1:0] alen;
    logic                  run;
    logic                  last_beat;
    logic [BW_AXI_DATA-1:0] beat_data;
    logic [BW_STRB-1:0]     beat_strb;

    assign alen      = info_q[ALEN_LSB +: TXN_ALEN_W];
    assign run       = enable_i & ~rst_i;
    assign last_beat = (cnt_q == alen);

    // Beats past the buffer depth are legal and carry zero data with zero strobe.
    always_comb begin
        beat_data = '0;
        beat_strb = '0;
        if (state_q == ST_SEND) begin
            for (int i = 0; i < MAX_NUM_AXI_DATA; i++) begin
                if (cnt_q == TXN_ALEN_W'(i)) begin
                    beat_data = row_q[i*BW_AXI_DATA +: BW_AXI_DATA];
                    beat_strb = '1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            info_q  <= '0;
            err_q   <= 1'b0;
        end else if (enable_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (txn_valid_i) begin
                        info_q  <= txn_info_i;
                        row_q   <= row_data_i;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= txn_info_i[SKIP_POS] ? ST_DONE : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (wready_i) begin
                        if (last_beat) begin
                            state_q <= ST_WAIT_B;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_B: begin
                    if (bvalid_i) begin
`ifdef DCA_LSU_WSENDER_BRESP_CHECK_EN
                        err_q <= bresp_i[1];
`endif
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign txn_ready_o  = run & (state_q == ST_IDLE);
    assign wvalid_o     = run & (state_q == ST_SEND);
    assign wdata_o      = beat_data;
    assign wstrb_o      = beat_strb;
    assign wlast_o      = (state_q == ST_SEND) & last_beat;
    assign bready_o     = run & (state_q == ST_WAIT_B);
    assign done_valid_o = run & (state_q == ST_DONE);
    assign done_info_o  = info_q;

`ifdef DCA_LSU_WSENDER_BRESP_CHECK_EN
    assign done_error_o = err_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^{bresp_i, err_q};
    assign done_error_o = 1'b0;
`endif

endmodule
